block_rescale_ctrl: RTL and testbench
=====================================

# block_rescale_ctrl

Two-pass block-floating-point rescale sequencer. It accepts a block of `len` signed mantissas, each with its own signed quantization exponent, and buffers them while tracking the block's maximum exponent. It then replays the block with every mantissa arithmetically right-shifted to that common exponent. It sits between the dot-product/accumulator output stage and any consumer that requires a single shared exponent per block.

## Interface

Parameters:
- `W`, 16: mantissa width (two's complement).
- `DEPTH`, 256: maximum block length; buffer size.
- `LW`, `$clog2(DEPTH)+1`: width of `len` and of the element counters.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low; clock `clk`.
- `start`  in  1  single-cycle pulse that begins a block; sampled only in IDLE.
- `len`  in  LW  block length; sampled with `start`; legal range 1..DEPTH.
- `abort`  in  1  synchronous cancel of the current block.
- `in_valid` / `in_ready`  in/out  1  input handshake.
- `in_data`  in  W  signed mantissa.
- `in_qbit`  in  6  signed exponent, range -32..31, already saturated upstream.
- `out_valid` / `out_ready`  out/in  1  output handshake.
- `out_data`  out  W  aligned mantissa.
- `out_qbit`  out  6  signed block exponent (max), constant for the whole drain.
- `out_last`  out  1  marks the final element of the block.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last output handshake.
- `err_len`  out  1  one-cycle pulse when `start` arrives with an illegal `len`.

## Operation

- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - `start` with 1 ≤ `len` ≤ DEPTH → LOAD; latch `len`; clear both counters.
  - `start` with `len` = 0 or `len` > DEPTH → pulse `err_len`; remain in IDLE.
- LOAD:
  - `in_ready` is 1.
  - Each input handshake writes {`in_data`, `in_qbit`} to buffer address `wr_cnt`, then increments `wr_cnt`.
  - Effective exponent: an element with `in_data` = 0 contributes -32.
  - Max tracking: the first element loads `qmax` unconditionally. Later elements replace `qmax` only when their effective exponent is strictly greater (signed compare).
  - The handshake with `wr_cnt` = len-1 → DRAIN.
- DRAIN:
  - Reads buffer addresses 0..len-1 in order.
  - Shift amount `d` = `qmax` − element exponent, always ≥ 0, up to 63.
  - `out_data` = `in_data` >>> min(d, W). For d ≥ W the result is all sign bits: 0 or -1.
  - `out_qbit` = `qmax`.
  - `out_last` = 1 on element len-1.
  - The handshake on the last element → DONE.
- DONE: pulse `done` for one cycle → IDLE.
- `abort`:
  - In LOAD or DRAIN: next state is IDLE. `out_valid` and `in_ready` drop on the next cycle. No `done` pulse.
  - In IDLE: ignored.
- `start` while `busy`: ignored.
- `abort` and `start` in the same cycle while in IDLE: `start` wins.

## Timing

- Reset values:
  - `in_ready`, `out_valid`, `out_last`, `busy`, `done`, `err_len`: 0.
  - `out_data`, `out_qbit`: 0.
  - State: IDLE. Counters and `qmax`: 0.
  - Buffer contents: don't-care.
- `busy` rises the cycle after an accepted `start`.
- `in_ready` rises the cycle after `start`. It falls the cycle after the last input handshake.
- Buffer read latency: 1 cycle, registered.
- First `out_valid` occurs 2 cycles after the last input handshake.
- Throughput: 1 element/cycle in both phases, given `in_valid` and `out_ready` held high.
- Minimum block time: len + 2 + len + 1 cycles.
- While `out_valid` && !`out_ready`: `out_data`, `out_qbit` and `out_last` hold stable. Read prefetch is absorbed by a 2-entry skid buffer, with no bubbles and no data loss.
- `out_valid` never drops without a handshake, except on `abort` or reset.
- `done` is asserted exactly 1 cycle after the last output handshake.

## Structure

- Package `block_rescale_pkg` holds:
  - `state_e` (IDLE, LOAD, DRAIN, DONE).
  - `qbit_t` (logic signed [5:0]).
  - `QBIT_MIN` = -32 and `QBIT_MAX` = 31.
  - The function `align_shift(data, d)` implementing the saturated arithmetic shift.
- Sub-module `rescale_buf`: simple dual-port RAM, DEPTH × (W+6), one write port, one read port with registered output.

## Test plan

- len=4; inputs (100,-3), (-8,2), (7,0), (0,31) → `qmax`=2; outputs 3, -8, 1, 0 (element 4 zero, exponent -32 → d=34 → 0); `out_last` on the 4th; `done` 1 cycle later.
- len=1; input (-1, -32) → output -1, `out_qbit` -32; latency from input handshake to `out_valid` is 2 cycles.
- len=3; exponents 31, -32, -32 with data 5, 1234, -1234 → outputs 5, 0, -1 (shift saturates at W).
- `out_ready` toggled 1-0-1-0 during a len=8 drain → all 8 outputs in order; `out_*` stable during stalls; no duplicates.
- `start` with len=0, then len=DEPTH+1 → two `err_len` pulses; `busy` stays 0. A `start` during LOAD is ignored.
- `abort` after 2 of 5 inputs, then a new len=2 block → new `qmax` reflects only the new block; no `done` for the aborted block. Asserting `rst_n` low mid-DRAIN → all outputs return to their reset values.

Source files
------------

// File: rtl/block_rescale_pkg.sv
// Shared types and the saturating alignment shift for the block-floating-point rescaler.
package block_rescale_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  typedef logic signed [5:0] qbit_t;

  localparam qbit_t QBIT_MIN = qbit_t'(-32);
  localparam qbit_t QBIT_MAX = qbit_t'(31);

  // Arithmetic right shift by min(d, w); data is a sign-extended w-bit mantissa.
  function automatic logic signed [63:0] align_shift(input logic signed [63:0] data,
                                                     input logic [5:0] d,
                                                     input int w);
    int sh;
    sh = (int'(d) > w) ? w : int'(d);
    return data >>> sh;
  endfunction

endpackage

// File: rtl/rescale_buf.sv
// Simple dual-port block buffer: one write port, one read port with registered output.
module rescale_buf #(
  parameter int DW    = 22,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/block_rescale_ctrl.sv
// Two-pass block rescaler: buffer a block while tracking its max exponent, then replay
// every mantissa shifted to that common exponent.
//   state | meaning
//   IDLE  | waiting for start; illegal len pulses err_len
//   LOAD  | accepting inputs into the buffer, tracking qmax
//   DRAIN | reading buffer back, aligned, through a 2-entry skid
//   DONE  | one-cycle done pulse
module block_rescale_ctrl
  import block_rescale_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LW-1:0]       len,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  input  logic signed [5:0]   in_qbit,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic signed [5:0]   out_qbit,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                err_len
);

  localparam int AW = $clog2(DEPTH);

  state_e              state, state_nxt;
  logic [LW-1:0]       len_q, wr_cnt, rd_cnt;
  qbit_t               qmax, in_qeff, rd_qeff;
  logic signed [W-1:0] rd_mant;
  logic [W+5:0]        rd_word;
  logic                rd_en, rd_vld, rd_last;
  logic [W:0]          skid0, skid1, stage_ent, out_ent;
  logic [1:0]          skid_cnt, occ_after, push_idx;
  logic                in_hs, out_hs, skid_pop, skid_push, len_ok, last_wr, abort_clr;

  assign len_ok    = (len != '0) && (len <= LW'(DEPTH));
  assign in_hs     = in_ready && in_valid;
  assign out_hs    = out_valid && out_ready;
  assign last_wr   = (wr_cnt == len_q - LW'(1));
  assign abort_clr = abort && (state == LOAD || state == DRAIN);
  // A zero mantissa carries no magnitude, so it must not pull qmax up.
  assign in_qeff   = (in_data == '0) ? QBIT_MIN : qbit_t'(in_qbit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && len_ok) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (abort)                 state_nxt = IDLE;
        else if (in_hs && last_wr) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)                 state_nxt = IDLE;
        else if (out_hs && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      qmax    <= '0;
      err_len <= 1'b0;
    end else begin
      err_len <= (state == IDLE) && start && !len_ok;
      if (state == IDLE && start && len_ok) begin
        len_q  <= len;
        wr_cnt <= '0;
        rd_cnt <= '0;
      end
      if (in_hs) begin
        wr_cnt <= wr_cnt + LW'(1);
        if (wr_cnt == '0 || in_qeff > qmax) qmax <= in_qeff;
      end
      if (rd_en) rd_cnt <= rd_cnt + LW'(1);
    end
  end

  rescale_buf #(.DW(W + 6), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (in_hs),
    .wr_addr (wr_cnt[AW-1:0]),
    .wr_data ({in_data, in_qeff}),
    .rd_en   (rd_en),
    .rd_addr (rd_cnt[AW-1:0]),
    .rd_data (rd_word)
  );

  // Only prefetch when the skid can still absorb everything in flight.
  assign occ_after = skid_cnt + {1'b0, rd_vld} - {1'b0, out_hs};
  assign rd_en     = (state == DRAIN) && !abort && (rd_cnt < len_q) && (occ_after < 2'd2);

  assign rd_mant   = rd_word[W+5:6];
  assign rd_qeff   = rd_word[5:0];
  assign stage_ent = {rd_last, W'(align_shift(64'(rd_mant), qmax - rd_qeff, W))};

  assign skid_pop  = out_hs && (skid_cnt != 2'd0);
  assign skid_push = rd_vld && !(out_hs && skid_cnt == 2'd0);
  assign push_idx  = skid_cnt - {1'b0, skid_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      skid_cnt <= '0;
      skid0    <= '0;
      skid1    <= '0;
    end else if (abort_clr) begin
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
      skid_cnt <= '0;
    end else begin
      rd_vld  <= rd_en;
      rd_last <= rd_en && (rd_cnt == len_q - LW'(1));
      if (skid_pop) skid0 <= skid1;
      if (skid_push) begin
        if (push_idx == 2'd0) skid0 <= stage_ent;
        else                  skid1 <= stage_ent;
      end
      skid_cnt <= skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};
    end
  end

  // Older skid entries always go out before the freshly read word.
  assign out_ent   = (skid_cnt != 2'd0) ? skid0 : stage_ent;
  assign out_valid = rd_vld || (skid_cnt != 2'd0);
  assign out_data  = out_valid ? out_ent[W-1:0] : '0;
  assign out_last  = out_valid && out_ent[W];
  assign out_qbit  = qmax;

endmodule

// File: tb/tb_block_rescale_ctrl.sv
// Directed, table-driven bench for block_rescale_ctrl with hand-computed expectations.
module tb_block_rescale_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [8:0]         len;
  logic               abort;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic signed [5:0]  in_qbit;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic signed [5:0]  out_qbit;
  logic               out_last;
  logic               busy;
  logic               done;
  logic               err_len;

  int checks = 0;
  int failures = 0;

  typedef struct { int d; int q; int e; } elem_t;
  typedef struct { int len; int qmax; bit stall; } blk_t;

  elem_t elems[25];
  blk_t  blks[8];

  always #5 clk = ~clk;

  block_rescale_ctrl #(.W(16), .DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_qbit   (in_qbit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_qbit  (out_qbit),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic feed(input int d, input int q);
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_qbit  = 6'(q);
    @(negedge clk);
    chk("in_ready_load", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_block(input int b);
    int base, n, k, cyc, first_v, pd, pl;
    bit pstall;
    base = 0;
    for (int i = 0; i < b; i++) base += blks[i].len;
    n = blks[b].len;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 9'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        @(posedge clk); #1;
        // one idle LOAD cycle is harmless: in_ready stays high
      end
      feed(elems[base + i].d, elems[base + i].q);
    end
    k = 0; cyc = 0; first_v = -1; pstall = 1'b0; pd = 0; pl = 0;
    while (k < n && cyc < 100) begin
      out_ready = blks[b].stall ? ((cyc % 2) == 1) : 1'b1;
      @(negedge clk);
      if (cyc == 0) chk("in_ready_drop", int'(in_ready), 0);
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid) begin
        if (pstall) begin
          chk("hold_data", int'(out_data), pd);
          chk("hold_last", int'(out_last), pl);
        end
        if (out_ready) begin
          chk($sformatf("blk%0d_data%0d", b, k), int'(out_data), elems[base + k].e);
          chk($sformatf("blk%0d_qbit%0d", b, k), int'(out_qbit), blks[b].qmax);
          chk($sformatf("blk%0d_last%0d", b, k), int'(out_last), (k == n - 1) ? 1 : 0);
          k++;
          pstall = 1'b0;
        end else begin
          pstall = 1'b1;
          pd = int'(out_data);
          pl = int'(out_last);
        end
      end
      chk("early_done", int'(done), 0);
      @(posedge clk); #1;
      cyc++;
    end
    if (k < n) begin
      checks++; failures++;
      $display("FAIL drain_timeout blk%0d got=%0d required=%0d", b, k, n);
    end
    chk("first_valid_latency", first_v, 1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("busy_in_done", int'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_clear", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic err_start(input int n);
    int cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 9'(n);
    @(negedge clk);
    cnt = int'(err_len);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    cnt += int'(err_len);
    chk($sformatf("err_len_pulses_len%0d", n), cnt, 1);
    chk("err_busy", int'(busy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_len_clear", int'(err_len), 0);
    chk("err_busy_still", int'(busy), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"},  int'(out_last), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_err_len"},   int'(err_len), 0);
    chk({tag, "_out_data"},  int'(out_data), 0);
    chk({tag, "_out_qbit"},  int'(out_qbit), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    elems = '{
      '{100, -3, 3}, '{-8, 2, -8}, '{7, 0, 1}, '{0, 31, 0},
      '{-1, -32, -1},
      '{5, 31, 5}, '{1234, -32, 0}, '{-1234, -32, -1},
      '{0, 5, 0}, '{0, -4, 0},
      '{-32768, -32, -2048}, '{16, -28, 16}, '{-100, -30, -25},
      '{32767, 0, 32767}, '{-5, -10, -1},
      '{8, 3, 8}, '{8, 3, 8}, '{8, 0, 1}, '{8, 1, 2},
      '{8, 2, 4}, '{-8, 3, -8}, '{0, 3, 0}, '{-64, 3, -64},
      '{40, -2, 40}, '{-40, -4, -10}
    };
    blks = '{
      '{4, 2, 1'b0}, '{1, -32, 1'b0}, '{3, 31, 1'b0}, '{2, -32, 1'b0},
      '{3, -28, 1'b0}, '{2, 0, 1'b0}, '{8, 3, 1'b1}, '{2, -2, 1'b0}
    };

    rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; in_qbit = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int b = 0; b < 7; b++) run_block(b);

    err_start(0);
    err_start(257);

    // len = DEPTH is the largest legal length
    @(posedge clk); #1;
    start = 1'b1; len = 9'd256;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    chk("len_depth_accepted", int'(busy), 1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("len_depth_abort_idle", int'(busy), 0);

    // start and abort together in IDLE: start wins
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; len = 9'd5;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_beats_abort", int'(busy), 1);
    @(posedge clk); #1;
    feed(1, 20);
    start = 1'b1; len = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(1, 25);
    @(negedge clk);
    chk("start_in_load_ignored", int'(in_ready), 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_no_done", int'(done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_no_done_late", int'(done), 0);
    run_block(7);

    // reset mid-drain with a stalled output
    @(posedge clk); #1;
    start = 1'b1; len = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    feed(7, 0);
    feed(9, 1);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_valid", int'(out_valid), 1);
    chk("pre_reset_data", int'(out_data), 3);
    chk("pre_reset_qbit", int'(out_qbit), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_drain_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
